lcd_bus_seq: RTL

Clocked HD44780-style LCD bus sequencer placed between the MCU external-bus decode and the LCD pins. It replaces direct combinational E generation.
- Captures MCU accesses to the LCD window and re-drives each as one properly timed LCD cycle (RS/RW setup, E pulse width, hold).
- Latches LCD read data.
- Exposes local busy/overrun status so firmware polls a register instead of relying on MCU strobe width.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_bus_seq_sync_edge.sv | 36 +++
 rtl/lcd_bus_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus sequencer: FSM encoding, local register
// map, status bit positions and default bus timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EHIGH = 2'd2,
        ST_HOLD  = 2'd3
    } lcd_state_e;

    localparam logic REG_RES  = 1'b0;
    localparam logic REG_STAT = 1'b1;

    localparam int unsigned STAT_BUSY_BIT = 7;
    localparam int unsigned STAT_OVR_BIT  = 6;

    localparam int unsigned T_AS_DEF = 2;
    localparam int unsigned T_PW_DEF = 6;
    localparam int unsigned T_H_DEF  = 2;

    // Counter reload for a phase lasting t clocks (counts t-1 down to 0).
    function automatic logic [7:0] phase_load(input int unsigned t);
        logic [7:0] v;
        v = 8'(t - 32'd1);
        return v;
    endfunction

    function automatic logic [7:0] stat_byte(input logic busy, input logic ovr);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_BUSY_BIT] = busy;
        s[STAT_OVR_BIT]  = ovr;
        return s;
    endfunction

endpackage

// File: rtl/lcd_bus_seq_sync_edge.sv
// Two-flop synchroniser for an asynchronous MCU strobe followed by a
// rising-edge detector producing a one-clock pulse.
module sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next-state for the synchroniser chain and the edge-history flop.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchroniser and history registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/lcd_bus_seq.sv
// Re-times MCU accesses to an HD44780-style LCD into clean RS/RW setup,
// E pulse and hold phases, and offers local result/status registers.
module lcd_bus_seq
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS = T_AS_DEF,
    parameter int unsigned T_PW = T_PW_DEF,
    parameter int unsigned T_H  = T_H_DEF
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_n_i,
    input  logic       mcu_cs_i,
    input  logic       mcu_wr_i,
    input  logic       mcu_rd_i,
    input  logic [2:0] mcu_addr_i3,
    input  logic [7:0] mcu_wrdat_i8,
    output logic [7:0] mcu_rddat_o8,
    input  logic [7:0] lcd_dat_i8,
    output logic [7:0] lcd_dat_o8,
    output logic       lcd_dat_oe_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic       busy_o
);

    if (T_AS < 1 || T_AS > 255) begin : g_bad_t_as
        $error("lcd_bus_seq: T_AS must be within 1..255");
    end
    if (T_PW < 1 || T_PW > 255) begin : g_bad_t_pw
        $error("lcd_bus_seq: T_PW must be within 1..255");
    end
    if (T_H < 1 || T_H > 255) begin : g_bad_t_h
        $error("lcd_bus_seq: T_H must be within 1..255");
    end

    localparam logic [7:0] AS_LD = phase_load(T_AS);
    localparam logic [7:0] PW_LD = phase_load(T_PW);
    localparam logic [7:0] H_LD  = phase_load(T_H);

    lcd_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rs_q, rs_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic [7:0] dat_q, dat_d;
    logic [7:0] res_q, res_d;
    logic       ovr_q, ovr_d;
    logic       e_q, e_d;
    logic       busy_q, busy_d;

    logic wr_rise;
    logic rd_rise;
    logic lcd_hit;
    logic stat_rd;

    sync_edge u_wr_sync (
        .clk_i   (sys_clk_i),
        .rst_n_i (sys_rst_n_i),
        .async_i (mcu_wr_i),
        .rise_o  (wr_rise)
    );

    sync_edge u_rd_sync (
        .clk_i   (sys_clk_i),
        .rst_n_i (sys_rst_n_i),
        .async_i (mcu_rd_i),
        .rise_o  (rd_rise)
    );

    // A simultaneous write edge masks the read edge, so it cannot clear ovr.
    assign lcd_hit = mcu_cs_i & ~mcu_addr_i3[2] & (wr_rise | rd_rise);
    assign stat_rd = mcu_cs_i & mcu_addr_i3[2] & (mcu_addr_i3[0] == REG_STAT)
                   & rd_rise & ~wr_rise;

    // Sequencer next-state, phase counter, latches and status flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        dat_d   = dat_q;
        res_d   = res_q;
        ovr_d   = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (lcd_hit) begin
                    state_d = ST_SETUP;
                    cnt_d   = AS_LD;
                    rw_d    = mcu_addr_i3[1];
                    rs_d    = mcu_addr_i3[0];
                    oe_d    = ~mcu_addr_i3[1];
                    dat_d   = mcu_wrdat_i8;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_EHIGH;
                    cnt_d   = PW_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_EHIGH: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = H_LD;
                    if (rw_q) begin
                        res_d = lcd_dat_i8;
                    end else begin
                        res_d = res_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    rw_d    = 1'b1;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Including the clock that HOLD ends: IDLE must be registered first.
        if (lcd_hit && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end else if (stat_rd) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        e_d    = (state_d == ST_EHIGH);
        busy_d = (state_d != ST_IDLE);
    end

    // Registered sequencer state and pin drivers, synchronous reset.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
            oe_q    <= 1'b0;
            dat_q   <= 8'd0;
            res_q   <= 8'd0;
            ovr_q   <= 1'b0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            dat_q   <= dat_d;
            res_q   <= res_d;
            ovr_q   <= ovr_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
        end
    end

    assign mcu_rddat_o8 = (mcu_cs_i & mcu_rd_i & mcu_addr_i3[2])
                        ? ((mcu_addr_i3[0] == REG_RES) ? res_q : stat_byte(busy_q, ovr_q))
                        : 8'hzz;

    assign lcd_dat_o8   = dat_q;
    assign lcd_dat_oe_o = oe_q;
    assign lcd_rs_o     = rs_q;
    assign lcd_rw_o     = rw_q;
    assign lcd_e_o      = e_q;
    assign busy_o       = busy_q;

endmodule
